// File: rtl/dbg_led_mux_if.sv
// Signal bundle between the debug taps / board controls and the LED display selector.
// The master side drives the taps and controls; the slave side is the selector itself.
interface dbg_led_mux_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned LED_W  = 32
);
    localparam int unsigned PAGES = DATA_W / LED_W;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        sel;
    logic [1:0]               mode;
    logic                     step_btn;
    logic                     freeze;
    logic [PG_W-1:0]          page;
    logic [LED_W-1:0]         led;
    logic [CH_W-1:0]          cur_ch;
    logic                     led_valid;

    modport master (
        output ch_data, sel, mode, step_btn, freeze, page,
        input  led, cur_ch, led_valid
    );

    modport slave (
        input  ch_data, sel, mode, step_btn, freeze, page,
        output led, cur_ch, led_valid
    );
endinterface

// File: rtl/dbg_led_mux.sv
// Debug display selector: picks one of NUM_CH debug words (manual, button-step or auto-scan),
// pages it onto a narrower LED bank, and can freeze a snapshot. All outputs are registered.
module dbg_led_mux #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned LED_W     = 32,
    parameter int unsigned SCAN_DIV  = 50000000,
    parameter int unsigned DB_CYCLES = 16
) (
    input logic           clk,
    input logic           rst,
    dbg_led_mux_if.slave  bus
);
    localparam int unsigned PAGES = DATA_W / LED_W;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned SC_W  = $clog2(SCAN_DIV);
    localparam int unsigned DB_W  = $clog2(DB_CYCLES);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } db_state_e;

    db_state_e         db_state_q, db_state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              sync1_q, sync2_q;
    logic              step_pulse;

    logic [CH_W-1:0]   ptr_q, ptr_d, ptr_next;
    logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic              mode_step, mode_auto, mode_manual;

    logic [CH_W-1:0]   man_ch, sel_ch;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_word, live_word, show_word;
    logic [LED_W-1:0]  led_d;

    logic              frozen_q, hold, capture;
    logic [DATA_W-1:0] snap_q;
    logic [LED_W-1:0]  led_q;
    logic [CH_W-1:0]   cur_ch_q;
    logic              led_valid_q;

    assign mode_step   = (bus.mode == 2'b01);
    assign mode_auto   = (bus.mode == 2'b10);
    assign mode_manual = !mode_step && !mode_auto;

    always_comb begin
        db_state_d = db_state_q;
        db_cnt_d   = db_cnt_q;
        step_pulse = 1'b0;
        case (db_state_q)
            StIdle: begin
                if (sync2_q) begin
                    db_state_d = StPressWait;
                    db_cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!sync2_q) begin
                    db_state_d = StIdle;
                end else if (db_cnt_q == DB_LAST) begin
                    db_state_d = StHeld;
                    step_pulse = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (!sync2_q) begin
                    db_state_d = StReleaseWait;
                    db_cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                if (sync2_q) begin
                    db_state_d = StHeld;
                end else if (db_cnt_q == DB_LAST) begin
                    db_state_d = StIdle;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: db_state_d = StIdle;
        endcase
    end

    assign ptr_next = (ptr_q == CH_LAST) ? '0 : ptr_q + 1'b1;

    // A scan tick and a step pulse landing together still advance by exactly one.
    always_comb begin
        ptr_d      = ptr_q;
        scan_cnt_d = '0;
        if (mode_auto) begin
            if (scan_cnt_q == SC_LAST || step_pulse) begin
                ptr_d = ptr_next;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end else if (mode_step && step_pulse) begin
            ptr_d = ptr_next;
        end
    end

    always_comb begin
        man_ch = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (bus.sel[i]) begin
                man_ch = CH_W'(i);
            end
        end
        sel_ch    = mode_manual ? man_ch : ptr_q;
        sel_valid = mode_manual ? |bus.sel : 1'b1;
        sel_word  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (sel_ch == CH_W'(i)) begin
                sel_word = bus.ch_data[i*DATA_W +: DATA_W];
            end
        end
        live_word = sel_valid ? sel_word : '0;
    end

    // hold uses the live freeze level so release shows the live word one cycle later.
    assign hold      = frozen_q && bus.freeze;
    assign capture   = bus.freeze && !frozen_q;
    assign show_word = hold ? snap_q : live_word;

    always_comb begin
        led_d = '0;
        for (int p = 0; p < int'(PAGES); p++) begin
            if (PAGES == 1 || bus.page == PG_W'(p)) begin
                led_d = show_word[p*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_state_q  <= StIdle;
            db_cnt_q    <= '0;
            ptr_q       <= '0;
            scan_cnt_q  <= '0;
            frozen_q    <= 1'b0;
            snap_q      <= '0;
            led_q       <= '0;
            cur_ch_q    <= '0;
            led_valid_q <= 1'b0;
        end else begin
            sync1_q    <= bus.step_btn;
            sync2_q    <= sync1_q;
            db_state_q <= db_state_d;
            db_cnt_q   <= db_cnt_d;
            ptr_q      <= ptr_d;
            scan_cnt_q <= scan_cnt_d;
            frozen_q   <= bus.freeze;
            if (capture) begin
                snap_q <= live_word;
            end
            led_q <= led_d;
            if (!hold) begin
                led_valid_q <= sel_valid;
                if (sel_valid) begin
                    cur_ch_q <= sel_ch;
                end
            end
        end
    end

    assign bus.led       = led_q;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.led_valid = led_valid_q;
endmodule

// File: tb/tb_dbg_led_mux.sv
// Directed bench for dbg_led_mux: three instances (32/8/16-bit LED banks) share one stimulus set.
module tb_dbg_led_mux;
    localparam logic [127:0] CH_DEF = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] ch_data;
    logic [3:0]   sel;
    logic [1:0]   mode;
    logic         step_btn;
    logic         freeze;
    logic         pg_a;
    logic [1:0]   pg_b;
    logic         pg_c;

    int total = 0;
    int bad   = 0;

    dbg_led_mux_if #(.DATA_W(32), .NUM_CH(4), .LED_W(32)) if_a ();
    dbg_led_mux_if #(.DATA_W(32), .NUM_CH(4), .LED_W(8))  if_b ();
    dbg_led_mux_if #(.DATA_W(32), .NUM_CH(4), .LED_W(16)) if_c ();

    assign if_a.ch_data = ch_data;  assign if_b.ch_data = ch_data;  assign if_c.ch_data = ch_data;
    assign if_a.sel = sel;          assign if_b.sel = sel;          assign if_c.sel = sel;
    assign if_a.mode = mode;        assign if_b.mode = mode;        assign if_c.mode = mode;
    assign if_a.step_btn = step_btn;
    assign if_b.step_btn = step_btn;
    assign if_c.step_btn = step_btn;
    assign if_a.freeze = freeze;    assign if_b.freeze = freeze;    assign if_c.freeze = freeze;
    assign if_a.page = pg_a;        assign if_b.page = pg_b;        assign if_c.page = pg_c;

    dbg_led_mux #(.DATA_W(32), .NUM_CH(4), .LED_W(32), .SCAN_DIV(4), .DB_CYCLES(16)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );
    dbg_led_mux #(.DATA_W(32), .NUM_CH(4), .LED_W(8), .SCAN_DIV(4), .DB_CYCLES(16)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );
    dbg_led_mux #(.DATA_W(32), .NUM_CH(4), .LED_W(16), .SCAN_DIV(4), .DB_CYCLES(16)) u_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        step_btn = 1'b1;
        repeat (20) tick();
        step_btn = 1'b0;
        repeat (22) tick();
    endtask

    logic [7:0] exp_b [4];

    initial begin
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        rst = 1'b1; ch_data = CH_DEF; sel = 4'b0000; mode = 2'b00;
        step_btn = 1'b0; freeze = 1'b0; pg_a = 1'b0; pg_b = 2'd0; pg_c = 1'b0;
        tick();
        tick();
        check("rst_led", if_a.led, 32'h0);
        check("rst_cur", 32'(if_a.cur_ch), 32'd0);
        check("rst_valid", 32'(if_a.led_valid), 32'd0);
        check("rst_led_b", 32'(if_b.led), 32'h0);

        // MANUAL: lowest set bit wins, empty select blanks.
        rst = 1'b0; sel = 4'b0110;
        tick();
        check("man_led", if_a.led, 32'h22222222);
        check("man_cur", 32'(if_a.cur_ch), 32'd1);
        check("man_valid", 32'(if_a.led_valid), 32'd1);
        sel = 4'b1000;
        tick();
        check("man3_led", if_a.led, 32'h44444444);
        check("man3_cur", 32'(if_a.cur_ch), 32'd3);
        sel = 4'b0000;
        tick();
        check("blank_led", if_a.led, 32'h0);
        check("blank_valid", 32'(if_a.led_valid), 32'd0);
        check("blank_cur", 32'(if_a.cur_ch), 32'd3);

        // STEP: bounce, long press, paging, wrap.
        mode = 2'b01;
        tick();
        check("step_cur0", 32'(if_a.cur_ch), 32'd0);
        check("step_led0", if_a.led, 32'h11111111);
        check("step_valid", 32'(if_a.led_valid), 32'd1);
        step_btn = 1'b1;
        repeat (5) tick();
        step_btn = 1'b0;
        repeat (30) tick();
        check("bounce_cur", 32'(if_a.cur_ch), 32'd0);
        step_btn = 1'b1;
        repeat (40) tick();
        check("hold_cur", 32'(if_a.cur_ch), 32'd1);
        step_btn = 1'b0;
        repeat (25) tick();
        check("release_cur", 32'(if_a.cur_ch), 32'd1);

        ch_data[63:32] = 32'hA1B2C3D4;
        pg_a = 1'b1;
        for (int p = 0; p < 4; p++) begin
            pg_b = 2'(p);
            pg_c = p[0];
            tick();
            check($sformatf("page8_%0d", p), 32'(if_b.led), 32'(exp_b[p]));
            check($sformatf("page16_%0d", p), 32'(if_c.led), p[0] ? 32'hA1B2 : 32'hC3D4);
        end
        check("page_ignored", if_a.led, 32'hA1B2C3D4);

        press();
        press();
        check("step_to3", 32'(if_a.cur_ch), 32'd3);
        for (int k = 0; k < 4; k++) begin
            press();
            check($sformatf("wrap_%0d", k), 32'(if_a.cur_ch), 32'(k));
        end

        // AUTO: 4-cycle dwell per channel from a clean reset.
        ch_data = CH_DEF; mode = 2'b10; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("scan_%0d", k), 32'(if_a.cur_ch), 32'((k / 4) % 4));
        end
        // Press timed so the debounced pulse lands on the tick at edge 40.
        tick();
        step_btn = 1'b1;
        repeat (18) tick();
        tick();
        check("coin_e40", 32'(if_a.cur_ch), 32'd1);
        tick();
        check("coin_e41", 32'(if_a.cur_ch), 32'd2);
        repeat (3) tick();
        check("coin_e44", 32'(if_a.cur_ch), 32'd2);
        tick();
        check("coin_e45", 32'(if_a.cur_ch), 32'd3);
        step_btn = 1'b0;

        // Freeze in AUTO at channel 2.
        rst = 1'b1;
        tick();
        rst = 1'b0; ch_data = CH_DEF;
        repeat (9) tick();
        check("frz_pre_cur", 32'(if_a.cur_ch), 32'd2);
        freeze = 1'b1;
        tick();
        check("frz_cap", if_a.led, 32'h33333333);
        ch_data[95:64] = 32'hDEADBEEF;
        repeat (5) tick();
        check("frz_led_a", if_a.led, 32'h33333333);
        check("frz_cur", 32'(if_a.cur_ch), 32'd2);
        repeat (5) tick();
        check("frz_led_b", if_a.led, 32'h33333333);
        freeze = 1'b0;
        tick();
        check("unfrz_led", if_a.led, 32'h22222222);
        check("unfrz_cur", 32'(if_a.cur_ch), 32'd1);
        repeat (4) tick();
        check("live_led", if_a.led, 32'hDEADBEEF);
        check("live_cur", 32'(if_a.cur_ch), 32'd2);

        // Reset while frozen at ptr 3 with the debouncer mid press-wait.
        repeat (3) tick();
        freeze = 1'b1; step_btn = 1'b1;
        tick();
        repeat (6) tick();
        check("pre_rst_led", if_a.led, 32'h44444444);
        check("pre_rst_cur", 32'(if_a.cur_ch), 32'd3);
        rst = 1'b1; freeze = 1'b0;
        tick();
        check("mid_rst_led", if_a.led, 32'h0);
        check("mid_rst_cur", 32'(if_a.cur_ch), 32'd0);
        check("mid_rst_valid", 32'(if_a.led_valid), 32'd0);
        rst = 1'b0; mode = 2'b01;
        tick();
        check("post_rst_led", if_a.led, 32'h11111111);
        check("post_rst_valid", 32'(if_a.led_valid), 32'd1);
        repeat (18) tick();
        check("requal_before", 32'(if_a.cur_ch), 32'd0);
        tick();
        check("requal_after", 32'(if_a.cur_ch), 32'd1);
        step_btn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
